adc128s_spi_model: RTL and testbench
====================================

Name: adc128s_spi_model

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used on the Segway board.
- Acts as an SPI slave to the Segway A2D interface.
- Four analog sources are presented as 12-bit digital inputs: left load cell, right load cell, steering pot and battery.
- Each conversion result is returned in the transaction after the one that addressed its channel (pipelined, like the real part).

Parameters:
- LDL_CH, 0, channel number mapped to ld_cell_lft
- LDR_CH, 4, channel number mapped to ld_cell_rght
- STR_CH, 5, channel number mapped to steerPot
- BAT_CH, 6, channel number mapped to batt

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  SPI slave select, active low
- SCLK  in  1  SPI serial clock from master (mode 0, idle low)
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- ld_cell_lft  in  12  left load cell value
- ld_cell_rght  in  12  right load cell value
- steerPot  in  12  steering potentiometer value
- batt  in  12  battery voltage value

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Input synchronization:
  - SS_n, SCLK and MOSI are each double-flopped into the clk domain.
  - A third flop on SCLK and on SS_n provides edge detection.
  - SCLK is required to be at most clk/8.
- Reset values: MISO=0, tx_shreg=0, rx_shreg=0, bit_cnt=0, chan_ptr=0, state=IDLE.
- State IDLE (SS_n high):
  - MISO=0.
  - On a detected SS_n fall: go to XFER and load tx_shreg = {4'b0000, value(chan_ptr)}.
  - value(ch) selects the port mapped by the parameters; unmapped channels (1,2,3,7 by default) give 12'h000.
  - The value is sampled at the SS_n fall; later input changes do not affect the current word.
- State XFER:
  - MISO = tx_shreg[15] at all times, so the MSB is valid before the first SCLK rise.
  - Detected SCLK rise: rx_shreg <= {rx_shreg[14:0], MOSI_sync}; bit_cnt++.
  - Detected SCLK fall: tx_shreg <= {tx_shreg[14:0], 1'b0}.
  - Detected SS_n rise with bit_cnt==16: chan_ptr <= rx_shreg[13:11]; go to IDLE; bit_cnt=0.
  - Detected SS_n rise with bit_cnt!=16 (aborted frame): chan_ptr unchanged; go to IDLE; bit_cnt=0.
  - More than 16 SCLK rises: bit_cnt saturates at 16; rx keeps shifting, so the last 16 bits count; tx shifts in zeros.
- Command word: bits [15:14] and [10:0] are ignored; [13:11] = channel for the next conversion.
- Latency: a value appears on MISO one full transaction after its channel is commanded. The first transaction after reset returns channel 0 (ld_cell_lft).
- Simultaneous SS_n rise and SCLK edge in the same clk cycle: the SS_n rise takes priority; the SCLK edge is ignored.
- Reset asserted mid-transaction: immediate return to reset values. The partial frame is discarded.

Optional Feature:
- Macro: ADC_MISO_TRISTATE_EN.
- Defined: MISO is driven 1'bz whenever state==IDLE or rst_n is low, so that several slaves can share the line.
- Undefined: MISO is driven 0 in IDLE, as in the base behaviour.
- XFER behaviour is identical in both builds.

Test Plan:
- Reset, ld_cell_lft=700, first frame with MOSI=16'h2000 (ch4) -> MISO word 16'h02BC (700); chan_ptr=4.
- ld_cell_rght=20: next frame with MOSI=16'h2800 (ch5) -> MISO 16'h0014; then steerPot=12'h800 frame with MOSI=16'h3000 (ch6) -> MISO 16'h0800.
- batt=12'hFFF after ch6 was commanded -> next frame returns 16'h0FFF; the 4 MSBs are always 0.
- Command ch2 (16'h1000), next frame -> 16'h0000. Abort a frame after 8 SCLKs sending ch6 -> chan_ptr stays 2.
- Change ld_cell_lft from 700 to 800 mid-frame while ch0 result is shifting -> full word still 16'h02BC; the following ch0 frame returns 16'h0320.
- Assert rst_n low mid-frame -> MISO=0 (or Z with ADC_MISO_TRISTATE_EN) immediately; next frame returns ch0 value.

Source files
------------

// File: rtl/adc128s_spi_model_if.sv
// SPI bus between the Segway A2D master and the ADC128S-style slave model.
interface adc128s_spi_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_spi_model.sv
// ADC128S-style 8-channel 12-bit SPI A2D slave; result of the commanded channel returns one frame later.
// Optional ADC_MISO_TRISTATE_EN: MISO floats (1'bz) while idle or in reset so slaves can share the line.
//
// state | meaning
// IDLE  | SS_n high, waiting for a frame; MISO parked
// XFER  | frame in progress; MISO = tx_shreg MSB
module adc128s_spi_model #(
  parameter logic [2:0] LDL_CH = 3'd0,
  parameter logic [2:0] LDR_CH = 3'd4,
  parameter logic [2:0] STR_CH = 3'd5,
  parameter logic [2:0] BAT_CH = 3'd6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  adc128s_spi_model_if.slave         spi,
  input  logic [11:0]                ld_cell_lft,
  input  logic [11:0]                ld_cell_rght,
  input  logic [11:0]                steerPot,
  input  logic [11:0]                batt
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_q, sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] tx_shreg;
  // Only the bits that can still reach the channel field [13:11] are kept.
  logic [13:0] rx_shreg;
  logic [4:0]  bit_cnt;
  logic [2:0]  chan_ptr;
  logic [11:0] sel_val;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], spi.SS_n};
      sclk_q <= {sclk_q[1:0], spi.SCLK};
      mosi_q <= {mosi_q[0], spi.MOSI};
    end
  end

  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign mosi_sync =  mosi_q[1];

  always_comb begin
    sel_val = 12'h000;
    if      (chan_ptr == LDL_CH) sel_val = ld_cell_lft;
    else if (chan_ptr == LDR_CH) sel_val = ld_cell_rght;
    else if (chan_ptr == STR_CH) sel_val = steerPot;
    else if (chan_ptr == BAT_CH) sel_val = batt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = XFER;
      XFER:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef ADC_MISO_TRISTATE_EN
    spi.MISO = (!rst_n || state == IDLE) ? 1'bz : tx_shreg[15];
`else
    spi.MISO = (state == XFER) ? tx_shreg[15] : 1'b0;
`endif
  end

  // SS_n rise wins over any SCLK edge seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shreg <= '0;
      rx_shreg <= '0;
      bit_cnt  <= '0;
      chan_ptr <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
      if (ss_fall) tx_shreg <= {4'b0000, sel_val};
    end else if (ss_rise) begin
      if (bit_cnt == 5'd16) chan_ptr <= rx_shreg[13:11];
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      rx_shreg <= {rx_shreg[12:0], mosi_sync};
      if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
    end else if (sclk_fall) begin
      tx_shreg <= {tx_shreg[14:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Self-checking bench for adc128s_spi_model: vector table, corner sequences and random frames vs. a channel model.
module tb_adc128s_spi_model;
  logic        clk;
  logic        rst_n;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;
  logic        idle_val;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          model_ch = 0;

  adc128s_spi_model_if spi ();

  adc128s_spi_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi.slave),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [15:0] cmd;
    int          nbits;
    logic [11:0] lft, rght, str, bat;
    bit          chg;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Word the real part returns for a channel, from the fixed channel map.
  function automatic logic [15:0] model_word(input int ch);
    case (ch)
      0:       return {4'h0, ld_cell_lft};
      4:       return {4'h0, ld_cell_rght};
      5:       return {4'h0, steerPot};
      6:       return {4'h0, batt};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic do_frame(input logic [31:0] mosi_w, input int nbits, input bit sim_end,
                          input bit chg, input logic [11:0] new_lft, output logic [31:0] miso_w);
    miso_w = '0;
    spi.SS_n = 1'b0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.MOSI = mosi_w[i];
      #50;
      spi.SCLK = 1'b1;
      miso_w = {miso_w[30:0], spi.MISO};
      if (chg && i == nbits - 8) ld_cell_lft = new_lft;
      #50;
      spi.SCLK = 1'b0;
    end
    #50;
    if (sim_end) begin
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b1;
      #50;
      spi.SCLK = 1'b0;
    end else begin
      spi.SS_n = 1'b1;
    end
    #100;
  endtask

  initial begin
    logic [31:0] got, exp;
    logic [15:0] cmd;
    int          nb;

`ifdef ADC_MISO_TRISTATE_EN
    idle_val = 1'bz;
`else
    idle_val = 1'b0;
`endif
    tbl[0] = '{16'h2000, 16, 12'd700, 12'd0,  12'h000, 12'h000, 1'b0, 16'h02BC};
    tbl[1] = '{16'h2800, 16, 12'd700, 12'd20, 12'h000, 12'h000, 1'b0, 16'h0014};
    tbl[2] = '{16'h3000, 16, 12'd700, 12'd20, 12'h800, 12'h000, 1'b0, 16'h0800};
    tbl[3] = '{16'h1000, 16, 12'd700, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h0FFF};
    tbl[4] = '{16'h0000, 16, 12'd700, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h0000};
    tbl[5] = '{16'h1000, 16, 12'd700, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h02BC};
    tbl[6] = '{16'h3000, 8,  12'd700, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h0000};
    tbl[7] = '{16'h0000, 16, 12'd700, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h0000};
    tbl[8] = '{16'h0000, 16, 12'd700, 12'd20, 12'h800, 12'hFFF, 1'b1, 16'h02BC};
    tbl[9] = '{16'h0000, 16, 12'd800, 12'd20, 12'h800, 12'hFFF, 1'b0, 16'h0320};

    rst_n = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    ld_cell_lft = '0; ld_cell_rght = '0; steerPot = '0; batt = '0;
    #1;
    check("reset_miso", {31'b0, spi.MISO}, {31'b0, idle_val});
    #29;
    rst_n = 1'b1;
    #40;

    for (int k = 0; k < 10; k++) begin
      ld_cell_lft = tbl[k].lft; ld_cell_rght = tbl[k].rght;
      steerPot = tbl[k].str;    batt = tbl[k].bat;
      do_frame({16'h0, tbl[k].cmd}, tbl[k].nbits, 1'b0, tbl[k].chg, 12'd800, got);
      exp = {16'h0, tbl[k].exp} >> (16 - tbl[k].nbits);
      check($sformatf("tbl%0d_word", k), got, exp);
      check($sformatf("tbl%0d_idle", k), {31'b0, spi.MISO}, {31'b0, idle_val});
      if (tbl[k].nbits == 16) model_ch = int'(tbl[k].cmd[13:11]);
    end

    // More than 16 SCLKs: last 16 MOSI bits command ch4, extra MISO bits are zero.
    do_frame({12'h0, 4'hF, 16'h2000}, 20, 1'b0, 1'b0, 12'd0, got);
    check("over16_word", got, {12'h0, model_word(model_ch), 4'h0});
    model_ch = 4;
    do_frame(32'h3000, 16, 1'b0, 1'b0, 12'd0, got);
    check("over16_next", got, {16'h0, model_word(model_ch)});
    model_ch = 6;

    // SS_n rise together with an SCLK rise: the extra edge must not shift the command.
    do_frame(32'h2000, 16, 1'b1, 1'b0, 12'd0, got);
    check("simul_word", got, {16'h0, model_word(model_ch)});
    model_ch = 4;
    do_frame(32'h0000, 16, 1'b0, 1'b0, 12'd0, got);
    check("simul_next", got, {16'h0, model_word(model_ch)});
    model_ch = 0;

    for (int r = 0; r < 24; r++) begin
      ld_cell_lft  = 12'($urandom_range(0, 4095));
      ld_cell_rght = 12'($urandom_range(0, 4095));
      steerPot     = 12'($urandom_range(0, 4095));
      batt         = 12'($urandom_range(0, 4095));
      cmd = 16'($urandom);
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
      do_frame({16'h0, cmd}, nb, 1'b0, 1'b0, 12'd0, got);
      exp = {16'h0, model_word(model_ch)} >> (16 - nb);
      check($sformatf("rand%0d_word", r), got, exp);
      if (nb == 16) model_ch = int'(cmd[13:11]);
    end

    // Reset in the middle of a frame: MISO parks at once, partial frame is lost.
    spi.SS_n = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      spi.MOSI = 1'b1;
      #50;
      spi.SCLK = 1'b1;
      #50;
      spi.SCLK = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", {31'b0, spi.MISO}, {31'b0, idle_val});
    #9;
    spi.SS_n = 1'b1;
    #20;
    rst_n = 1'b1;
    #40;
    model_ch = 0;
    ld_cell_lft = 12'h123;
    do_frame(32'h2800, 16, 1'b0, 1'b0, 12'd0, got);
    check("rst_next_word", got, {16'h0, model_word(model_ch)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
